// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar scheduler: FSM state encoding and 64 MHz timing defaults.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    REPORT,
    GAP
  } sonar_state_e;

  localparam int unsigned DEF_N_SENSORS   = 4;
  localparam int unsigned DEF_CNT_W       = 22;
  localparam int unsigned DEF_TRIG_CYCLES = 640;
  localparam int unsigned DEF_TIMEOUT     = 2_560_000;
  localparam int unsigned DEF_GAP_CYCLES  = 64_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sonar_echo_timer.sv
// Echo front end for the selected sensor: synchronizer, edge detect, pulse width and timeout.
module sonar_echo_timer #(
  parameter int unsigned N_SENSORS = 4,
  parameter int unsigned CNT_W     = 22,
  parameter int unsigned TIMEOUT   = 2_560_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SENSORS-1:0]         echo,
  input  logic [$clog2(N_SENSORS)-1:0] sel,
  input  logic                         clear,
  input  logic                         waiting,
  input  logic                         measuring,
  output logic                         rise,
  output logic                         fall,
  output logic                         timeout_hit,
  output logic [CNT_W-1:0]             width
);

  logic [N_SENSORS-1:0] sync1;
  logic [N_SENSORS-1:0] sync2;
  logic                 lvl;
  logic [CNT_W-1:0]     timer;

  // lvl lags the synchronized bit by one cycle; MEASURE counts lvl so a pulse of
  // W synchronized cycles yields exactly W.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= 1'b0;
      timer <= '0;
      width <= '0;
    end else begin
      sync1 <= echo;
      sync2 <= sync1;
      lvl   <= sync2[sel];

      if (clear) begin
        timer <= '0;
      end else if (waiting || measuring) begin
        timer <= timer + 1'b1;
      end

      if (waiting && rise) begin
        width <= '0;
      end else if (measuring && lvl && (width != '1)) begin
        width <= width + 1'b1;
      end
    end
  end

  assign rise        = waiting & sync2[sel] & ~lvl;
  assign fall        = measuring & ~lvl;
  assign timeout_hit = (waiting | measuring) & (timer == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic sensor sequencer: one trigger at a time, echo width or timeout
// per sensor, plus a per-sensor near flag.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int unsigned N_SENSORS   = DEF_N_SENSORS,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TRIG_CYCLES = DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [CNT_W-1:0]             near_thresh,
  input  logic [N_SENSORS-1:0]         echo,
  output logic [N_SENSORS-1:0]         trigger,
  output logic                         dist_valid,
  output logic [$clog2(N_SENSORS)-1:0] dist_id,
  output logic [CNT_W-1:0]             dist_count,
  output logic                         dist_timeout,
  output logic [N_SENSORS-1:0]         near,
  output logic                         busy
);

  localparam int unsigned ID_W = $clog2(N_SENSORS);
  localparam int unsigned PH_W = $clog2(max_u(TRIG_CYCLES, GAP_CYCLES) + 1);

  sonar_state_e     state_q;
  sonar_state_e     state_d;
  logic [PH_W-1:0]  phase_cnt;
  logic [ID_W-1:0]  idx;
  logic             report_to;
  logic             gap_done;
  logic             trig_done;
  logic             rise;
  logic             fall;
  logic             timeout_hit;
  logic [CNT_W-1:0] width;

  sonar_echo_timer #(
    .N_SENSORS(N_SENSORS),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT)
  ) u_echo_timer (
    .clk        (clk),
    .rst        (rst),
    .echo       (echo),
    .sel        (idx),
    .clear      (state_q == TRIG),
    .waiting    (state_q == WAIT_RISE),
    .measuring  (state_q == MEASURE),
    .rise       (rise),
    .fall       (fall),
    .timeout_hit(timeout_hit),
    .width      (width)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    report_to = 1'b0;
    trig_done = (phase_cnt == PH_W'(TRIG_CYCLES - 1));
    gap_done  = (state_q == GAP) && (phase_cnt == PH_W'(GAP_CYCLES - 1));
    case (state_q)
      IDLE: begin
        if (enable) state_d = TRIG;
      end
      TRIG: begin
        if (trig_done) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (timeout_hit) begin
          state_d   = REPORT;
          report_to = 1'b1;
        end else if (rise) begin
          state_d = MEASURE;
        end
      end
      // Echo fall takes priority over a coincident timeout.
      MEASURE: begin
        if (fall) begin
          state_d = REPORT;
        end else if (timeout_hit) begin
          state_d   = REPORT;
          report_to = 1'b1;
        end
      end
      REPORT: begin
        state_d = GAP;
      end
      GAP: begin
        if (gap_done) state_d = enable ? TRIG : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trigger = '0;
    if (state_q == TRIG) trigger[idx] = 1'b1;
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt    <= '0;
      idx          <= '0;
      dist_valid   <= 1'b0;
      dist_id      <= '0;
      dist_count   <= '0;
      dist_timeout <= 1'b0;
      near         <= '0;
    end else begin
      if (state_d != state_q) begin
        phase_cnt <= '0;
      end else if ((state_q == TRIG) || (state_q == GAP)) begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      if (gap_done) begin
        idx <= (idx == ID_W'(N_SENSORS - 1)) ? '0 : idx + 1'b1;
      end

      dist_valid <= 1'b0;
      if (state_d == REPORT) begin
        dist_valid   <= 1'b1;
        dist_id      <= idx;
        dist_timeout <= report_to;
        dist_count   <= report_to ? CNT_W'(TIMEOUT) : width;
        near[idx]    <= !report_to && (width <= near_thresh);
      end
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with small timing parameters (2 sensors, 8-bit counts).
module tb_sonar_scheduler;

  localparam int unsigned N_S  = 2;
  localparam int unsigned CW   = 8;
  localparam int unsigned TRC  = 4;
  localparam int unsigned TOUT = 100;
  localparam int unsigned GAPC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] near_thresh = 8'd20;
  logic [N_S-1:0] echo = '0;
  logic [N_S-1:0] trigger;
  logic          dist_valid;
  logic [0:0]    dist_id;
  logic [CW-1:0] dist_count;
  logic          dist_timeout;
  logic [N_S-1:0] near;
  logic          busy;

  int vectors = 0;
  int errors  = 0;

  sonar_scheduler #(
    .N_SENSORS  (N_S),
    .CNT_W      (CW),
    .TRIG_CYCLES(TRC),
    .TIMEOUT    (TOUT),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .near_thresh (near_thresh),
    .echo        (echo),
    .trigger     (trigger),
    .dist_valid  (dist_valid),
    .dist_id     (dist_id),
    .dist_count  (dist_count),
    .dist_timeout(dist_timeout),
    .near        (near),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits for the next trigger pulse and returns its sensor and high time; returns on
  // the first sample with trigger low again.
  task automatic wait_trig(output int id, output int hi);
    int n;
    id = -1;
    hi = 0;
    n  = 0;
    while (trigger == '0 && n < 400) begin
      tick();
      n++;
    end
    if (trigger != '0) begin
      id = trigger[1] ? 1 : 0;
      while (trigger != '0 && hi < 50) begin
        hi++;
        tick();
      end
    end
  endtask

  task automatic wait_result(input int max, output bit got, output int elapsed);
    elapsed = 0;
    while (!dist_valid && elapsed < max) begin
      tick();
      elapsed++;
    end
    got = dist_valid;
  endtask

  task automatic pulse_echo(input int s, input int delay, input int w);
    repeat (delay) tick();
    echo[s] = 1'b1;
    repeat (w) tick();
    echo[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    echo = '0;
    near_thresh = 8'd20;
    repeat (3) tick();
    vectors++;
    if (trigger !== 2'b00 || dist_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_ctrl trig=%b valid=%b busy=%b want 00/0/0", trigger, dist_valid, busy);
      errors++;
    end
    vectors++;
    if (dist_count !== 8'd0 || dist_id !== 1'b0 || dist_timeout !== 1'b0 || near !== 2'b00) begin
      $display("FAIL reset_data count=%0d id=%0d to=%b near=%b want 0/0/0/00",
               dist_count, dist_id, dist_timeout, near);
      errors++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_echo();
    int id, hi, el;
    bit got;
    enable = 1'b1;
    wait_trig(id, hi);
    vectors++;
    if (id != 0 || hi != int'(TRC)) begin
      $display("FAIL t1_trigger id=%0d high=%0d want 0/%0d", id, hi, TRC);
      errors++;
    end
    pulse_echo(0, 5, 30);
    wait_result(100, got, el);
    vectors++;
    if (!got || dist_id !== 1'b0 || dist_count !== 8'd30 || dist_timeout !== 1'b0) begin
      $display("FAIL t1_result got=%b id=%0d count=%0d to=%b want 1/0/30/0",
               got, dist_id, dist_count, dist_timeout);
      errors++;
    end
    vectors++;
    if (near[0] !== 1'b0) begin
      $display("FAIL t1_near0 got %b want 0", near[0]);
      errors++;
    end
    tick();
    vectors++;
    if (dist_valid !== 1'b0) begin
      $display("FAIL t1_strobe_width valid=%b want 0", dist_valid);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int id, hi, el;
    bit got;
    wait_trig(id, hi);
    vectors++;
    if (id != 1 || hi != int'(TRC)) begin
      $display("FAIL t2_trigger id=%0d high=%0d want 1/%0d", id, hi, TRC);
      errors++;
    end
    wait_result(150, got, el);
    vectors++;
    if (!got || dist_id !== 1'b1 || dist_count !== 8'd100 || dist_timeout !== 1'b1) begin
      $display("FAIL t2_result got=%b id=%0d count=%0d to=%b want 1/1/100/1",
               got, dist_id, dist_count, dist_timeout);
      errors++;
    end
    vectors++;
    if (near[1] !== 1'b0) begin
      $display("FAIL t2_near1 got %b want 0", near[1]);
      errors++;
    end
  endtask

  task automatic test_round_robin();
    int seq[4];
    int n, last_fall, min_gap, multi;
    logic [N_S-1:0] prev;
    n = 0; last_fall = -1; min_gap = 100000; multi = 0;
    prev = trigger;
    for (int t = 0; t < 1200 && n < 4; t++) begin
      tick();
      if ($countones(trigger) > 1) multi++;
      if (trigger != '0 && prev == '0) begin
        seq[n] = trigger[1] ? 1 : 0;
        if (last_fall >= 0 && (t - last_fall) < min_gap) min_gap = t - last_fall;
        n++;
      end
      if (trigger == '0 && prev != '0) last_fall = t;
      prev = trigger;
    end
    vectors++;
    if (n != 4) begin
      $display("FAIL t3_trigger_count got %0d want 4", n);
      errors++;
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (seq[k] != (k % 2)) begin
          $display("FAIL t3_order[%0d] got %0d want %0d", k, seq[k], k % 2);
          errors++;
        end
      end
    end
    vectors++;
    if (multi != 0) begin
      $display("FAIL t3_onehot multi_high_cycles=%0d want 0", multi);
      errors++;
    end
    vectors++;
    if (min_gap < int'(GAPC)) begin
      $display("FAIL t3_gap min=%0d want >=%0d", min_gap, GAPC);
      errors++;
    end
  endtask

  task automatic test_near();
    int id, hi, el;
    bit got;
    wait_result(300, got, el);
    vectors++;
    if (!got) begin
      $display("FAIL t4_flush got=%b want 1", got);
      errors++;
    end
    near_thresh = 8'd20;
    wait_trig(id, hi);
    pulse_echo(0, 3, 15);
    wait_result(100, got, el);
    vectors++;
    if (!got || dist_id !== 1'b0 || dist_count !== 8'd15 || near !== 2'b01) begin
      $display("FAIL t4_w15 got=%b id=%0d count=%0d near=%b want 1/0/15/01",
               got, dist_id, dist_count, near);
      errors++;
    end
    wait_trig(id, hi);
    pulse_echo(1, 3, 20);
    wait_result(100, got, el);
    vectors++;
    if (!got || dist_id !== 1'b1 || dist_count !== 8'd20 || near !== 2'b11) begin
      $display("FAIL t4_w20_boundary got=%b id=%0d count=%0d near=%b want 1/1/20/11",
               got, dist_id, dist_count, near);
      errors++;
    end
    wait_trig(id, hi);
    pulse_echo(0, 3, 25);
    wait_result(100, got, el);
    vectors++;
    if (!got || dist_id !== 1'b0 || dist_count !== 8'd25 || near !== 2'b10) begin
      $display("FAIL t4_w25 got=%b id=%0d count=%0d near=%b want 1/0/25/10",
               got, dist_id, dist_count, near);
      errors++;
    end
  endtask

  task automatic test_echo_held();
    int n, el;
    bit got;
    n = 0;
    while (trigger == '0 && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (trigger !== 2'b10) begin
      $display("FAIL t5_trigger got %b want 10", trigger);
      errors++;
    end
    echo[1] = 1'b1;
    n = 0;
    while (trigger != '0 && n < 50) begin
      tick();
      n++;
    end
    wait_result(150, got, el);
    vectors++;
    if (!got || dist_id !== 1'b1 || dist_count !== 8'd100 || dist_timeout !== 1'b1) begin
      $display("FAIL t5_result got=%b id=%0d count=%0d to=%b want 1/1/100/1",
               got, dist_id, dist_count, dist_timeout);
      errors++;
    end
    vectors++;
    if (el < int'(TOUT) || el > int'(TOUT) + 2) begin
      $display("FAIL t5_latency got %0d cycles want %0d..%0d", el, TOUT, TOUT + 2);
      errors++;
    end
    echo[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int id, hi, el;
    bit got;
    wait_trig(id, hi);
    pulse_echo(0, 2, 5);
    wait_result(100, got, el);
    vectors++;
    if (!got || dist_id !== 1'b0 || dist_count !== 8'd5 || dist_timeout !== 1'b0) begin
      $display("FAIL t6_w5 got=%b id=%0d count=%0d to=%b want 1/0/5/0",
               got, dist_id, dist_count, dist_timeout);
      errors++;
    end
    wait_trig(id, hi);
    vectors++;
    if (id != 1) begin
      $display("FAIL t6_pre_id got %0d want 1", id);
      errors++;
    end
    repeat (3) tick();
    echo[1] = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (trigger !== 2'b00 || dist_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL t6_rst trig=%b valid=%b busy=%b want 00/0/0", trigger, dist_valid, busy);
      errors++;
    end
    rst = 1'b0;
    echo[1] = 1'b0;
    wait_trig(id, hi);
    vectors++;
    if (id != 0 || hi != int'(TRC) || dist_valid !== 1'b0) begin
      $display("FAIL t6_restart id=%0d high=%0d valid=%b want 0/%0d/0", id, hi, dist_valid, TRC);
      errors++;
    end
  endtask

  task automatic test_enable_stop();
    int id, hi, el, n, stray;
    bit got;
    enable = 1'b0;
    pulse_echo(0, 2, 12);
    wait_result(100, got, el);
    vectors++;
    if (!got || dist_id !== 1'b0 || dist_count !== 8'd12 || dist_timeout !== 1'b0) begin
      $display("FAIL t6_stop_result got=%b id=%0d count=%0d to=%b want 1/0/12/0",
               got, dist_id, dist_count, dist_timeout);
      errors++;
    end
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0 || n > int'(GAPC) + 2) begin
      $display("FAIL t6_idle busy=%b after %0d cycles want 0 within %0d", busy, n, GAPC + 2);
      errors++;
    end
    stray = 0;
    repeat (20) begin
      tick();
      if (trigger != '0 || dist_valid) stray++;
    end
    vectors++;
    if (stray != 0) begin
      $display("FAIL t6_quiet activity_cycles=%0d want 0", stray);
      errors++;
    end
    enable = 1'b1;
    wait_trig(id, hi);
    vectors++;
    if (id != 1 || hi != int'(TRC)) begin
      $display("FAIL t6_resume id=%0d high=%0d want 1/%0d", id, hi, TRC);
      errors++;
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_timeout();
    test_round_robin();
    test_near();
    test_echo_held();
    test_reset_mid();
    test_enable_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
